// File: rtl/dff_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : dff_input_debouncer
//  Description : Synchronises a raw asynchronous level into clk, rejects
//                glitches shorter than STABLE_CYCLES consecutive samples and
//                drives a clean registered level d_out.
//                Optional macro DEBOUNCE_EDGE_OUT_EN adds the registered
//                rise/fall edge-pulse ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_input_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 4,
    parameter int STABLE_CYCLES = 8,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic r,
    input  logic din,
    output logic d_out,
    output logic busy
`ifdef DEBOUNCE_EDGE_OUT_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter range checks
    // ------------------------------------------------------------------
    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("dff_input_debouncer: SYNC_STAGES must be >= 2");
        end
        if ((STABLE_CYCLES < 1) || (STABLE_CYCLES > ((1 << CNT_W) - 1))) begin : g_bad_stable_cycles
            $error("dff_input_debouncer: STABLE_CYCLES must be in 1 .. 2**CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam bit               c_single   = (STABLE_CYCLES == 1);

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_QUAL   = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    logic                   w_diff;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_dout;
    logic                   w_dout_nxt;

    // Plain shift-register synchroniser; stage 0 captures the raw input
    always_ff @(posedge clk) begin
        if (!r) begin
            r_sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_diff = w_s ^ r_dout;

    // State, qualification counter and debounced level registers
    always_ff @(posedge clk) begin
        if (!r) begin
            r_state <= ST_STABLE;
            r_cnt   <= c_cnt_zero;
            r_dout  <= RESET_LEVEL;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dout  <= w_dout_nxt;
        end
    end

    // Next-state: count consecutive edges where the synchronised level
    // disagrees with d_out; accept the change on the STABLE_CYCLES-th one
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dout_nxt  = r_dout;
        case (r_state)
            ST_STABLE: begin
                if (w_diff) begin
                    if (c_single) begin
                        w_dout_nxt = w_s;
                    end else begin
                        w_state_nxt = ST_QUAL;
                        w_cnt_nxt   = c_cnt_one;
                    end
                end
            end
            ST_QUAL: begin
                if (!w_diff) begin
                    // Glitch rejected: level returned before qualification
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = c_cnt_zero;
                end else if (r_cnt == c_cnt_last) begin
                    w_dout_nxt  = w_s;
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = c_cnt_zero;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
                w_cnt_nxt   = c_cnt_zero;
            end
        endcase
    end

    assign d_out = r_dout;
    assign busy  = (r_state == ST_QUAL);

`ifdef DEBOUNCE_EDGE_OUT_EN
    logic r_rise;
    logic r_fall;

    // Edge pulses registered on the same edge that d_out changes
    always_ff @(posedge clk) begin
        if (!r) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= ~r_dout &  w_dout_nxt;
            r_fall <=  r_dout & ~w_dout_nxt;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`endif

endmodule
`default_nettype wire
